// File: rtl/vga_pkg.sv
// Shared timing constants for the 1024x768@60 Hz VGA path.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_STOP  = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_STOP  = V_SYNC_START + V_SYNC;

  localparam logic SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-(MAX+1) counter with enable; exposes the registered value,
// the value it will take next, and a wrap strobe.
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int MAX   = H_TOTAL - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    wrap  = en && (cnt_q == MAX_V);
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign nxt = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: pixel/line counters with sync, blank and
// frame-start flags registered alongside the counters.
module vga_timing_gen #(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic        frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VA  = 11'(V_ACTIVE);
  localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        h_wrap;
  logic        v_wrap;

  vga_wrap_counter #(.WIDTH(11), .MAX(H_TOT - 1)) u_hcnt (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .cnt  (hcount),
    .nxt  (h_nxt),
    .wrap (h_wrap)
  );

  vga_wrap_counter #(.WIDTH(11), .MAX(V_TOT - 1)) u_vcnt (
    .clk  (clk),
    .rst  (rst),
    .en   (h_wrap),
    .cnt  (vcount),
    .nxt  (v_nxt),
    .wrap (v_wrap)
  );

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic hblnk_q, hblnk_d;
  logic vblnk_q, vblnk_d;
  logic fs_q, fs_d;

  // Decode the upcoming counter pair so flags land with it.
  always_comb begin
    hsync_d = (h_nxt >= HS0 && h_nxt < HS1) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_nxt >= VS0 && v_nxt < VS1) ? SYNC_POL : ~SYNC_POL;
    hblnk_d = (h_nxt >= HA);
    vblnk_d = (v_nxt >= VA);
    fs_d    = v_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      hblnk_q <= hblnk_d;
      vblnk_q <= vblnk_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full-size generator for line timing, a reduced
// geometry instance for frame, vsync and mid-frame reset behaviour.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic hs;
    logic vs;
    logic hb;
    logic vb;
    logic fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [10:0] hc_d, vc_d, hc_s, vc_s;
  logic hs_d, vs_d, hb_d, vb_d, fs_d;
  logic hs_s, vs_s, hb_s, vb_s, fs_s;

  exp_t act_def, act_sm, ed, es;
  exp_t q_def[$];
  exp_t q_sm[$];

  int passed = 0;
  int total  = 0;

  int dh = 0, dv = 0, sh = 0, sv = 0;
  bit dfs = 0, sfs = 0;

  localparam exp_t RST_DEF = {11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam exp_t RST_SM  = {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  vga_timing_gen dut_def (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hc_d),
    .vcount      (vc_d),
    .hsync       (hs_d),
    .vsync       (vs_d),
    .hblnk       (hb_d),
    .vblnk       (vb_d),
    .frame_start (fs_d)
  );

  // 25 x 15 total, active-high sync
  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (10), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b1)
  ) dut_sm (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hc_s),
    .vcount      (vc_s),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .hblnk       (hb_s),
    .vblnk       (vb_s),
    .frame_start (fs_s)
  );

  assign act_def = {hc_d, vc_d, hs_d, vs_d, hb_d, vb_d, fs_d};
  assign act_sm  = {hc_s, vc_s, hs_s, vs_s, hb_s, vb_s, fs_s};

  function automatic exp_t mk(int h, int v, bit fs,
                              int ha, int hs0, int hs1,
                              int va, int vs0, int vs1, bit pol);
    exp_t e;
    e.h  = 11'(h);
    e.v  = 11'(v);
    e.hs = (h >= hs0 && h < hs1) ? pol : ~pol;
    e.vs = (v >= vs0 && v < vs1) ? pol : ~pol;
    e.hb = (h >= ha);
    e.vb = (v >= va);
    e.fs = fs;
    return e;
  endfunction

  // Advance the reference model by one clock edge and queue expectations.
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      dh = 0; dv = 0; sh = 0; sv = 0; dfs = 0; sfs = 0;
    end else begin
      dfs = 0;
      if (dh == 1343) begin
        dh = 0;
        if (dv == 805) begin dv = 0; dfs = 1; end else dv++;
      end else dh++;
      sfs = 0;
      if (sh == 24) begin
        sh = 0;
        if (sv == 14) begin sv = 0; sfs = 1; end else sv++;
      end else sh++;
    end
    q_def.push_back(mk(dh, dv, dfs, 1024, 1048, 1184, 768, 771, 777, 1'b0));
    q_sm.push_back(mk(sh, sv, sfs, 16, 18, 22, 10, 11, 13, 1'b1));
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      cyc();
      ed = q_def.pop_front();
      es = q_sm.pop_front();
      total += 2;
      if (act_def !== ed)
        $display("FAIL reset_def act=%h exp=%h", act_def, ed);
      else passed++;
      if (act_sm !== es)
        $display("FAIL reset_sm act=%h exp=%h", act_sm, es);
      else passed++;
    end
    #2 rst = 1'b0;
    cyc();
    ed = q_def.pop_front();
    es = q_sm.pop_front();
    total += 3;
    if (act_def !== ed)
      $display("FAIL release_def act=%h exp=%h", act_def, ed);
    else passed++;
    if (act_sm !== es)
      $display("FAIL release_sm act=%h exp=%h", act_sm, es);
    else passed++;
    if (hc_d !== 11'd1)
      $display("FAIL first_edge hcount=%0d exp=1", hc_d);
    else passed++;
  endtask

  task automatic test_line();
    int hsn = 0;
    int hbn = 0;
    int ph, pv;
    for (int i = 0; i < 2700; i++) begin
      ph = int'(hc_d);
      pv = int'(vc_d);
      cyc();
      ed = q_def.pop_front();
      es = q_sm.pop_front();
      total += 2;
      if (act_def !== ed)
        $display("FAIL line_def act=%h exp=%h", act_def, ed);
      else passed++;
      if (act_sm !== es)
        $display("FAIL line_sm act=%h exp=%h", act_sm, es);
      else passed++;
      if (ph == 1343) begin
        total++;
        if (hc_d !== 11'd0 || vc_d !== 11'(pv + 1))
          $display("FAIL hwrap h=%0d v=%0d exp=0,%0d", hc_d, vc_d, pv + 1);
        else passed++;
      end
      if (vc_d == 11'd1) begin
        if (hs_d == 1'b0) hsn++;
        if (hb_d) hbn++;
      end
    end
    total += 2;
    if (hsn != 136)
      $display("FAIL hsync_width got=%0d exp=136", hsn);
    else passed++;
    if (hbn != 320)
      $display("FAIL hblnk_width got=%0d exp=320", hbn);
    else passed++;
  endtask

  task automatic test_frame();
    int nfs = 0;
    int last = 0;
    int vsn = 0, vbn = 0, hsn = 0;
    for (int i = 0; i < 790; i++) begin
      cyc();
      ed = q_def.pop_front();
      es = q_sm.pop_front();
      total += 3;
      if (act_def !== ed)
        $display("FAIL frame_def act=%h exp=%h", act_def, ed);
      else passed++;
      if (act_sm !== es)
        $display("FAIL frame_sm act=%h exp=%h", act_sm, es);
      else passed++;
      if (hc_s >= 11'd25 || vc_s >= 11'd15)
        $display("FAIL range h=%0d v=%0d lim=25,15", hc_s, vc_s);
      else passed++;
      if (fs_s) begin
        nfs++;
        if (nfs >= 2) begin
          total++;
          if (i - last != 375)
            $display("FAIL fs_period got=%0d exp=375", i - last);
          else passed++;
        end
        last = i;
      end
      if (nfs == 1) begin
        if (vs_s) vsn++;
        if (vb_s) vbn++;
        if (hs_s) hsn++;
      end
    end
    total += 4;
    if (nfs < 2)
      $display("FAIL fs_count got=%0d exp>=2", nfs);
    else passed++;
    if (vsn != 50)
      $display("FAIL vsync_width got=%0d exp=50", vsn);
    else passed++;
    if (vbn != 125)
      $display("FAIL vblnk_width got=%0d exp=125", vbn);
    else passed++;
    if (hsn != 60)
      $display("FAIL hsync_frame got=%0d exp=60", hsn);
    else passed++;
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    int n = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc();
      ed = q_def.pop_front();
      es = q_sm.pop_front();
      total += 2;
      if (act_def !== ed)
        $display("FAIL seek_def act=%h exp=%h", act_def, ed);
      else passed++;
      if (act_sm !== es)
        $display("FAIL seek_sm act=%h exp=%h", act_sm, es);
      else passed++;
      if (hc_s == 11'd7 && vc_s == 11'd4) found = 1;
    end
    total++;
    if (!found) $display("FAIL seek_timeout h=%0d v=%0d exp=7,4", hc_s, vc_s);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total += 2;
    if (act_def !== RST_DEF)
      $display("FAIL async_def act=%h exp=%h", act_def, RST_DEF);
    else passed++;
    if (act_sm !== RST_SM)
      $display("FAIL async_sm act=%h exp=%h", act_sm, RST_SM);
    else passed++;
    cyc();
    ed = q_def.pop_front();
    es = q_sm.pop_front();
    total += 2;
    if (act_def !== ed)
      $display("FAIL held_def act=%h exp=%h", act_def, ed);
    else passed++;
    if (act_sm !== es)
      $display("FAIL held_sm act=%h exp=%h", act_sm, es);
    else passed++;
    #2 rst = 1'b0;
    found = 0;
    for (int i = 1; i <= 400 && !found; i++) begin
      cyc();
      ed = q_def.pop_front();
      es = q_sm.pop_front();
      total += 2;
      if (act_def !== ed)
        $display("FAIL restart_def act=%h exp=%h", act_def, ed);
      else passed++;
      if (act_sm !== es)
        $display("FAIL restart_sm act=%h exp=%h", act_sm, es);
      else passed++;
      if (fs_s) begin found = 1; n = i; end
    end
    total++;
    if (n != 375)
      $display("FAIL restart_period got=%0d exp=375", n);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
